// File: rtl/kf8237_channel_programmer.sv
// Programs one KF8237 channel (mask, clrff, mode, addr, count, page, unmask) from a single start request.
// Latency: one cycle per step with io_ready high; done pulses the cycle after the last step.
// Backpressure: each bus step holds its strobe/address/data until io_ready; optional readback via KF8237_PROGRAMMER_READBACK_EN.
module kf8237_channel_programmer #(
    parameter bit UNMASK_ON_DONE = 1'b1,
    parameter bit PAGE_ENABLE    = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  channel,
    input  logic [5:0]  mode,
    input  logic [15:0] address,
    input  logic [15:0] word_count,
    input  logic [7:0]  page,
    output logic        busy,
    output logic        done,
    output logic        verify_error,
    output logic [3:0]  io_address,
    output logic [7:0]  io_data_out,
    output logic        io_write,
    output logic        io_read,
    input  logic [7:0]  io_data_in,
    input  logic        io_ready,
    output logic        page_write,
    output logic [1:0]  page_channel,
    output logic [7:0]  page_data
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_MASK   = 4'd1;
    localparam logic [3:0] S_CLRFF  = 4'd2;
    localparam logic [3:0] S_MODE   = 4'd3;
    localparam logic [3:0] S_ADLO   = 4'd4;
    localparam logic [3:0] S_ADHI   = 4'd5;
    localparam logic [3:0] S_CNLO   = 4'd6;
    localparam logic [3:0] S_CNHI   = 4'd7;
    localparam logic [3:0] S_PAGE   = 4'd8;
    localparam logic [3:0] S_UNMASK = 4'd9;
`ifdef KF8237_PROGRAMMER_READBACK_EN
    localparam logic [3:0] S_RBCLR  = 4'd10;
    localparam logic [3:0] S_RALO   = 4'd11;
    localparam logic [3:0] S_RAHI   = 4'd12;
    localparam logic [3:0] S_RCLO   = 4'd13;
    localparam logic [3:0] S_RCHI   = 4'd14;
`endif

    // Disabled steps are folded out of the successor chain so they cost no cycles.
    localparam logic [3:0] S_AFTER_PAGE = UNMASK_ON_DONE ? S_UNMASK : S_IDLE;
    localparam logic [3:0] S_AFTER_READ = PAGE_ENABLE ? S_PAGE : S_AFTER_PAGE;
`ifdef KF8237_PROGRAMMER_READBACK_EN
    localparam logic [3:0] S_AFTER_CNHI = S_RBCLR;
`else
    localparam logic [3:0] S_AFTER_CNHI = S_AFTER_READ;
`endif

    logic [3:0]  state;
    logic [3:0]  step_next;
    logic [3:0]  nxt;
    logic [1:0]  ch_q;
    logic [5:0]  mode_q;
    logic [15:0] addr_q;
    logic [15:0] cnt_q;
    logic [7:0]  page_q;
    logic        rd_strobe;
    logic [7:0]  rd_expect;
    logic        accept;

    assign busy         = (state != S_IDLE);
    assign accept       = (state == S_IDLE) && start;
    assign page_write   = (state == S_PAGE);
    assign page_channel = ch_q;
    assign page_data    = page_q;

    always_comb begin
        io_address  = 4'h0;
        io_data_out = 8'h00;
        io_write    = 1'b0;
        rd_strobe   = 1'b0;
        rd_expect   = 8'h00;
        step_next   = state;
        case (state)
            S_IDLE:   step_next = start ? S_MASK : S_IDLE;
            S_MASK: begin
                io_address  = 4'hA;
                io_data_out = {5'b0, 1'b1, ch_q};
                io_write    = 1'b1;
                step_next   = S_CLRFF;
            end
            S_CLRFF: begin
                io_address  = 4'hC;
                io_write    = 1'b1;
                step_next   = S_MODE;
            end
            S_MODE: begin
                io_address  = 4'hB;
                io_data_out = {mode_q, ch_q};
                io_write    = 1'b1;
                step_next   = S_ADLO;
            end
            S_ADLO: begin
                io_address  = {1'b0, ch_q, 1'b0};
                io_data_out = addr_q[7:0];
                io_write    = 1'b1;
                step_next   = S_ADHI;
            end
            S_ADHI: begin
                io_address  = {1'b0, ch_q, 1'b0};
                io_data_out = addr_q[15:8];
                io_write    = 1'b1;
                step_next   = S_CNLO;
            end
            S_CNLO: begin
                io_address  = {1'b0, ch_q, 1'b1};
                io_data_out = cnt_q[7:0];
                io_write    = 1'b1;
                step_next   = S_CNHI;
            end
            S_CNHI: begin
                io_address  = {1'b0, ch_q, 1'b1};
                io_data_out = cnt_q[15:8];
                io_write    = 1'b1;
                step_next   = S_AFTER_CNHI;
            end
`ifdef KF8237_PROGRAMMER_READBACK_EN
            // Second pointer clear: the readback pairs must start on the low byte.
            S_RBCLR: begin
                io_address  = 4'hC;
                io_write    = 1'b1;
                step_next   = S_RALO;
            end
            S_RALO: begin
                io_address  = {1'b0, ch_q, 1'b0};
                rd_strobe   = 1'b1;
                rd_expect   = addr_q[7:0];
                step_next   = S_RAHI;
            end
            S_RAHI: begin
                io_address  = {1'b0, ch_q, 1'b0};
                rd_strobe   = 1'b1;
                rd_expect   = addr_q[15:8];
                step_next   = S_RCLO;
            end
            S_RCLO: begin
                io_address  = {1'b0, ch_q, 1'b1};
                rd_strobe   = 1'b1;
                rd_expect   = cnt_q[7:0];
                step_next   = S_RCHI;
            end
            S_RCHI: begin
                io_address  = {1'b0, ch_q, 1'b1};
                rd_strobe   = 1'b1;
                rd_expect   = cnt_q[15:8];
                step_next   = S_AFTER_READ;
            end
`endif
            S_PAGE:   step_next = S_AFTER_PAGE;
            S_UNMASK: begin
                io_address  = 4'hA;
                io_data_out = {6'b0, ch_q};
                io_write    = 1'b1;
                step_next   = S_IDLE;
            end
            default:  step_next = S_IDLE;
        endcase
    end

    // A bus step only advances on a posedge where the slave accepts it.
    assign nxt = ((io_write || rd_strobe) && !io_ready) ? state : step_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            done   <= 1'b0;
            ch_q   <= 2'b0;
            mode_q <= 6'b0;
            addr_q <= 16'h0;
            cnt_q  <= 16'h0;
            page_q <= 8'h0;
        end else begin
            state <= nxt;
            done  <= (state != S_IDLE) && (nxt == S_IDLE);
            if (accept) begin
                ch_q   <= channel;
                mode_q <= mode;
                addr_q <= address;
                cnt_q  <= word_count;
                page_q <= page;
            end
        end
    end

`ifdef KF8237_PROGRAMMER_READBACK_EN
    logic verr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            verr_q <= 1'b0;
        end else if (accept) begin
            verr_q <= 1'b0;
        end else if (rd_strobe && io_ready && (io_data_in != rd_expect)) begin
            verr_q <= 1'b1;
        end
    end

    assign io_read      = rd_strobe;
    assign verify_error = verr_q;
`else
    logic unused_rd;

    assign unused_rd    = ^{io_data_in, rd_expect, rd_strobe};
    assign io_read      = 1'b0;
    assign verify_error = 1'b0;
`endif

endmodule

// File: tb/tb_kf8237_channel_programmer.sv
// Directed bench: expected bus writes/page strobes are queued at start and popped as the DUT issues them.
module tb_kf8237_channel_programmer;

`ifdef KF8237_PROGRAMMER_READBACK_EN
    localparam int RB  = 5;
    localparam int RBW = 1;
`else
    localparam int RB  = 0;
    localparam int RBW = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start, start_np;
    logic [1:0]  channel;
    logic [5:0]  mode;
    logic [15:0] address, word_count;
    logic [7:0]  page;
    logic [7:0]  io_data_in;
    logic        io_ready;
    logic        corrupt;

    logic        busy, done, verify_error, io_write, io_read, page_write;
    logic [3:0]  io_address;
    logic [7:0]  io_data_out, page_data;
    logic [1:0]  page_channel;

    logic        np_busy, np_done, np_verify_error, np_io_write, np_io_read, np_page_write;
    logic [3:0]  np_io_address;
    logic [7:0]  np_io_data_out, np_page_data;
    logic [1:0]  np_page_channel;

    int tests = 0;
    int fails = 0;
    int np_writes = 0;
    int np_pages = 0;
    logic [12:0] sbq[$];
    logic [12:0] m_obs;
    logic [12:0] m_exp;

    always #5 clock = ~clock;

    kf8237_channel_programmer dut (
        .clock(clock), .reset(reset), .start(start), .channel(channel), .mode(mode),
        .address(address), .word_count(word_count), .page(page),
        .busy(busy), .done(done), .verify_error(verify_error),
        .io_address(io_address), .io_data_out(io_data_out), .io_write(io_write), .io_read(io_read),
        .io_data_in(io_data_in), .io_ready(io_ready),
        .page_write(page_write), .page_channel(page_channel), .page_data(page_data)
    );

    kf8237_channel_programmer #(.UNMASK_ON_DONE(1'b0), .PAGE_ENABLE(1'b0)) dut_np (
        .clock(clock), .reset(reset), .start(start_np), .channel(channel), .mode(mode),
        .address(address), .word_count(word_count), .page(page),
        .busy(np_busy), .done(np_done), .verify_error(np_verify_error),
        .io_address(np_io_address), .io_data_out(np_io_data_out), .io_write(np_io_write), .io_read(np_io_read),
        .io_data_in(io_data_in), .io_ready(io_ready),
        .page_write(np_page_write), .page_channel(np_page_channel), .page_data(np_page_data)
    );

`ifdef KF8237_PROGRAMMER_READBACK_EN
    // Minimal slave: per-port 16-bit registers behind a shared byte pointer.
    logic [15:0] regs [0:7];
    logic        ff = 1'b0;

    always @(posedge clock) begin
        if (io_ready) begin
            if (io_write && io_address == 4'hC) begin
                ff <= 1'b0;
            end else if ((io_write || io_read) && io_address < 4'h8) begin
                if (io_write && ff)  regs[io_address[2:0]][15:8] <= io_data_out;
                if (io_write && !ff) regs[io_address[2:0]][7:0]  <= io_data_out;
                ff <= ~ff;
            end
        end
    end

    assign io_data_in = (ff ? regs[io_address[2:0]][15:8] : regs[io_address[2:0]][7:0]) ^ {7'b0, corrupt};
`else
    assign io_data_in = 8'h00;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (io_write && io_ready) begin
            m_obs = {1'b0, io_address, io_data_out};
            if (sbq.size() == 0) chk("sb_extra_write", {19'b0, m_obs}, 32'hFFFF_FFFF);
            else begin
                m_exp = sbq.pop_front();
                chk("sb_bus_write", {19'b0, m_obs}, {19'b0, m_exp});
            end
        end
        if (page_write) begin
            m_obs = {1'b1, 2'b00, page_channel, page_data};
            if (sbq.size() == 0) chk("sb_extra_page", {19'b0, m_obs}, 32'hFFFF_FFFF);
            else begin
                m_exp = sbq.pop_front();
                chk("sb_page", {19'b0, m_obs}, {19'b0, m_exp});
            end
        end
        if (np_io_write && io_ready) np_writes++;
        if (np_page_write) np_pages++;
    end

    task automatic push_seq(input logic [1:0] ch, input logic [5:0] md, input logic [15:0] ad,
                            input logic [15:0] cn, input logic [7:0] pg);
        sbq.push_back({1'b0, 4'hA, 5'b0, 1'b1, ch});
        sbq.push_back({1'b0, 4'hC, 8'h00});
        sbq.push_back({1'b0, 4'hB, md, ch});
        sbq.push_back({1'b0, 1'b0, ch, 1'b0, ad[7:0]});
        sbq.push_back({1'b0, 1'b0, ch, 1'b0, ad[15:8]});
        sbq.push_back({1'b0, 1'b0, ch, 1'b1, cn[7:0]});
        sbq.push_back({1'b0, 1'b0, ch, 1'b1, cn[15:8]});
        if (RBW != 0) sbq.push_back({1'b0, 4'hC, 8'h00});
        sbq.push_back({1'b1, 2'b00, ch, pg});
        sbq.push_back({1'b0, 4'hA, 6'b0, ch});
    endtask

    task automatic run_seq(input logic [1:0] ch, input logic [5:0] md, input logic [15:0] ad,
                           input logic [15:0] cn, input logic [7:0] pg, input int stall,
                           input int repulse, input int rst_at, input int exp_done, input int tail);
        int cyc;
        int done_at;
        int ndone;
        channel = ch; mode = md; address = ad; word_count = cn; page = pg;
        start = 1'b1;
        push_seq(ch, md, ad, cn, pg);
        tick();
        start = 1'b0;
        cyc = 1;
        done_at = 0;
        ndone = 0;
        chk("busy_first_cycle", {31'b0, busy}, 32'd1);
        while (cyc < 60) begin
            if (rst_at == cyc) begin
                reset = 1'b0;
                #1;
                chk("rst_io_write", {31'b0, io_write}, 32'd0);
                chk("rst_io_read", {31'b0, io_read}, 32'd0);
                chk("rst_page_write", {31'b0, page_write}, 32'd0);
                chk("rst_busy", {31'b0, busy}, 32'd0);
                chk("rst_done", {31'b0, done}, 32'd0);
                tick();
                reset = 1'b1;
                sbq.delete();
                return;
            end
            if (stall > 0 && cyc >= stall && cyc <= stall + 3) begin
                chk("stall_io_write", {31'b0, io_write}, 32'd1);
                chk("stall_io_address", {28'b0, io_address}, {28'b0, 1'b0, ch, 1'b0});
                chk("stall_io_data", {24'b0, io_data_out}, {24'b0, ad[15:8]});
                io_ready = (cyc == stall + 3);
            end
            if (repulse == cyc) begin
                start = 1'b1;
                address = ~ad;
                channel = ch + 2'd1;
            end
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = cyc;
                chk("busy_low_at_done", {31'b0, busy}, 32'd0);
                if (tail == 0) break;
            end
            if (done_at != 0 && cyc >= done_at + tail) break;
            tick();
            cyc++;
            start = 1'b0;
        end
        chk("done_cycle", done_at, exp_done);
        chk("done_pulses", ndone, 32'd1);
        chk("sb_drained", sbq.size(), 32'd0);
    endtask

    initial begin
        int cyc;
        reset = 1'b0; start = 1'b0; start_np = 1'b0; io_ready = 1'b1; corrupt = 1'b0;
        channel = 2'd0; mode = 6'd0; address = 16'h0; word_count = 16'h0; page = 8'h0;
        #2;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_verify_error", {31'b0, verify_error}, 32'd0);
        chk("reset_io_strobes", {29'b0, io_write, io_read, page_write}, 32'd0);
        chk("reset_io_address", {28'b0, io_address}, 32'd0);
        chk("reset_io_data_out", {24'b0, io_data_out}, 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick(); tick();
        chk("idle_ignores_ready", {30'b0, busy, io_write}, 32'd0);

        run_seq(2'd2, 6'h12, 16'h1234, 16'h00FF, 8'h05, 0, 0, 0, 10 + RB, 3);
        chk("io_read_idle", {31'b0, io_read}, 32'd0);
        chk("verify_ok", {31'b0, verify_error}, 32'd0);

        run_seq(2'd2, 6'h12, 16'h1234, 16'h00FF, 8'h05, 5, 0, 0, 13 + RB, 2);
        run_seq(2'd1, 6'h05, 16'hA55A, 16'h0102, 8'h7E, 0, 3, 0, 10 + RB, 4);
        run_seq(2'd3, 6'h3F, 16'h8001, 16'hFFFE, 8'hC3, 0, 0, 6, 0, 0);
        chk("post_reset_idle", {31'b0, busy}, 32'd0);
        run_seq(2'd0, 6'h22, 16'h00AA, 16'h1000, 8'h11, 0, 0, 0, 10 + RB, 0);
        run_seq(2'd3, 6'h2D, 16'h5678, 16'h0040, 8'h99, 0, 0, 0, 10 + RB, 2);

        np_writes = 0;
        np_pages = 0;
        channel = 2'd1; mode = 6'h01; address = 16'h4321; word_count = 16'h0007; page = 8'h22;
        start_np = 1'b1;
        tick();
        start_np = 1'b0;
        cyc = 1;
        while (!np_done && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("np_done_cycle", cyc, 8 + RB);
        chk("np_busy_at_done", {31'b0, np_busy}, 32'd0);
        chk("np_write_count", np_writes, 7 + RBW);
        chk("np_page_count", np_pages, 32'd0);

`ifdef KF8237_PROGRAMMER_READBACK_EN
        run_seq(2'd0, 6'h11, 16'hBEEF, 16'h0010, 8'h0A, 0, 0, 0, 15, 2);
        chk("rb_match", {31'b0, verify_error}, 32'd0);
        corrupt = 1'b1;
        run_seq(2'd1, 6'h11, 16'hBEEF, 16'h0010, 8'h0A, 0, 0, 0, 15, 2);
        corrupt = 1'b0;
        tick(); tick();
        chk("rb_mismatch_sticky", {31'b0, verify_error}, 32'd1);
        run_seq(2'd1, 6'h11, 16'hBEEF, 16'h0010, 8'h0A, 0, 0, 0, 15, 2);
        chk("rb_cleared_by_start", {31'b0, verify_error}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
